// File: rtl/osecpu_pkg.sv
// Shared OSECPU definitions: sequencer state codes and opcode values.
// Used by both the fetch sequencer and the datapath so the encodings never drift apart.
package osecpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_EXEC   = 4'd1,
        ST_FETCH  = 4'd2,
        ST_DECODE = 4'd3,
        ST_HALT   = 4'd15
    } state_e;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LB     = 8'h01;
    localparam logic [7:0] OP_LIMM16 = 8'h02;
    localparam logic [7:0] OP_OR     = 8'h10;
    localparam logic [7:0] OP_XOR    = 8'h11;
    localparam logic [7:0] OP_AND    = 8'h12;
    localparam logic [7:0] OP_ADD    = 8'h14;
    localparam logic [7:0] OP_SUB    = 8'h15;
    localparam logic [7:0] OP_SHL    = 8'h18;
    localparam logic [7:0] OP_SAR    = 8'h19;
    localparam logic [7:0] OP_CP     = 8'hd2;
    localparam logic [7:0] OP_CPDR   = 8'hd3;
    localparam logic [7:0] OP_END    = 8'hff;

    // Opcodes that the datapath acts on during EXEC.
    function automatic logic isExecOp(input logic [7:0] op);
        case (op)
            OP_LIMM16, OP_CP, OP_CPDR,
            OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB, OP_SHL, OP_SAR: isExecOp = 1'b1;
            default:                                               isExecOp = 1'b0;
        endcase
    endfunction

    function automatic logic isSkipOp(input logic [7:0] op);
        isSkipOp = (op == OP_NOP) || (op == OP_LB);
    endfunction

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode classifier: exactly one of exec/skip/end/illegal is high.
module opcode_classify
    import osecpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic       exec_o,
    output logic       skip_o,
    output logic       end_o,
    output logic       illegal_o
);

    always_comb begin
        exec_o    = isExecOp(opcode_i);
        skip_o    = isSkipOp(opcode_i);
        end_o     = (opcode_i == OP_END);
        illegal_o = !(exec_o || skip_o || end_o);
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// OSECPU fetch/sequencing stage: PC, req/ack instruction fetch, decode and halt control.
// All memory-side and status outputs come straight from flops, never from inputs.
module instr_fetch_seq
    import osecpu_pkg::*;
#(
    parameter int                    PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0]   START_ADDR = '0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr0,
    output logic [3:0]          current_state,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                illegal
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                illegal_q, illegal_d;
    logic                req_q, halted_q;

    logic opExec, opSkip, opEnd, opIllegal;

    opcode_classify u_classify (
        .opcode_i  (instr_q[31:24]),
        .exec_o    (opExec),
        .skip_o    (opSkip),
        .end_o     (opEnd),
        .illegal_o (opIllegal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = START_ADDR;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opExec) begin
                    state_d = ST_EXEC;
                end else if (opSkip) begin
                    state_d = ST_FETCH;
                end else if (opEnd) begin
                    state_d = ST_HALT;
                end else if (opIllegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    illegal_d = 1'b0;
                    pc_d      = START_ADDR;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // req/halted are registered from the next state so they stay free of input paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_ADDR;
            instr_q   <= 32'h0;
            illegal_q <= 1'b0;
            req_q     <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            req_q     <= (state_d == ST_FETCH);
            halted_q  <= (state_d == ST_HALT);
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr0        = instr_q;
    assign current_state = state_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: a program-level model queues the expected
// per-cycle state/pc/instr0/illegal, a memory responder serves fetches with configurable wait.
module tb_instr_fetch_seq;

    localparam int PCW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_ack;
    logic [31:0]    imem_rdata;
    logic [31:0]    instr0;
    logic [3:0]     current_state;
    logic [PCW-1:0] pc;
    logic           halted;
    logic           illegal;

    always #5 clk = ~clk;

    instr_fetch_seq #(.PC_WIDTH(PCW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr0        (instr0),
        .current_state (current_state),
        .pc            (pc),
        .halted        (halted),
        .illegal       (illegal)
    );

    typedef struct {
        logic [3:0]     st;
        logic [PCW-1:0] pc;
        logic [31:0]    instr;
        logic           ill;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mem[16];
    logic [31:0] lastInstr;
    int          ackDelay;
    int          waitCnt;
    bit          respOn;
    int          errorCount = 0;
    int          checkCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic respond();
        if (!respOn) return;
        if (imem_req === 1'b1) begin
            if (waitCnt >= ackDelay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hdeadbeef;
            end
            waitCnt++;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hdeadbeef;
            waitCnt    = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        respond();
    endtask

    function automatic bit isExec(input logic [7:0] op);
        case (op)
            8'h02, 8'hd2, 8'hd3, 8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h18, 8'h19: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Walks the program as the spec describes it and queues one record per clock.
    task automatic pushProgram(input int maxInstr);
        logic [PCW-1:0] pcM    = '0;
        logic [31:0]    instrM = lastInstr;
        logic           ill    = 1'b0;
        logic [7:0]     op;
        for (int n = 0; n < maxInstr; n++) begin
            for (int w = 0; w <= ackDelay; w++) expQ.push_back('{4'd2, pcM, instrM, ill});
            instrM = mem[pcM];
            pcM    = pcM + 1'b1;
            expQ.push_back('{4'd3, pcM, instrM, ill});
            op = instrM[31:24];
            if (isExec(op)) begin
                expQ.push_back('{4'd1, pcM, instrM, ill});
            end else if (op != 8'h00 && op != 8'h01) begin
                if (op != 8'hff) ill = 1'b1;
                expQ.push_back('{4'd15, pcM, instrM, ill});
                expQ.push_back('{4'd15, pcM, instrM, ill});
                break;
            end
        end
        lastInstr = instrM;
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic runScoreboard(input string name, output int execSeen);
        exp_t e;
        execSeen = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({name, ".state"},   32'(current_state), 32'(e.st));
            checkOutput({name, ".pc"},      32'(pc),            32'(e.pc));
            checkOutput({name, ".instr0"},  instr0,             e.instr);
            checkOutput({name, ".illegal"}, 32'(illegal),       32'(e.ill));
            checkOutput({name, ".req"},     32'(imem_req),      32'(e.st == 4'd2));
            checkOutput({name, ".halted"},  32'(halted),        32'(e.st == 4'd15));
            if (e.st == 4'd2) checkOutput({name, ".addr"}, 32'(imem_addr), 32'(e.pc));
            if (current_state == 4'd1) execSeen++;
            step();
        end
    endtask

    task automatic applyReset();
        rst_n    = 1'b0;
        start    = 1'b0;
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        lastInstr = 32'h0;
        step();
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, ".state"},   32'(current_state), 32'd0);
        checkOutput({name, ".pc"},      32'(pc),            32'd0);
        checkOutput({name, ".instr0"},  instr0,             32'h0);
        checkOutput({name, ".req"},     32'(imem_req),      32'd0);
        checkOutput({name, ".addr"},    32'(imem_addr),     32'd0);
        checkOutput({name, ".halted"},  32'(halted),        32'd0);
        checkOutput({name, ".illegal"}, 32'(illegal),       32'd0);
    endtask

    initial begin
        int execSeen;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        respOn     = 1'b1;
        ackDelay   = 0;
        waitCnt    = 0;
        imem_rdata = 32'h0;
        lastInstr  = 32'h0;

        applyReset();
        checkResetValues("reset");

        mem[0] = 32'h02040005; mem[1] = 32'hff000000;
        pushProgram(8);
        applyStimulus();
        runScoreboard("limm", execSeen);
        checkOutput("limm.execCount", execSeen, 1);

        mem[0] = 32'h00000000; mem[1] = 32'h01000000; mem[2] = 32'h14041080; mem[3] = 32'hff000000;
        pushProgram(8);
        applyStimulus();
        runScoreboard("prog", execSeen);
        checkOutput("prog.execCount", execSeen, 1);

        ackDelay = 4;
        mem[0] = 32'h10000000; mem[1] = 32'hff000000;
        pushProgram(8);
        applyStimulus();
        runScoreboard("wait", execSeen);
        ackDelay = 0;

        mem[0] = 32'h77000000;
        pushProgram(8);
        applyStimulus();
        runScoreboard("illop", execSeen);
        mem[0] = 32'h02000000; mem[1] = 32'hff000000;
        pushProgram(8);
        applyStimulus();
        runScoreboard("restart", execSeen);

        // Async reset while a fetch is stalled, then an ack that arrives too late.
        ackDelay = 1000;
        applyStimulus();
        step();
        step();
        checkOutput("midrst.pre", 32'(current_state), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues("midrst");
        respOn     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h02000000;
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        checkOutput("lateack.state",  32'(current_state), 32'd0);
        checkOutput("lateack.instr0", instr0,             32'h0);
        checkOutput("lateack.req",    32'(imem_req),      32'd0);
        imem_ack  = 1'b0;
        respOn    = 1'b1;
        ackDelay  = 0;
        lastInstr = 32'h0;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h01000000;
        pushProgram(17);
        applyStimulus();
        runScoreboard("wrap", execSeen);
        applyReset();
        checkResetValues("final");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch and sequencing stage directly upstream of the OSECPU datapath. Holds the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and latches them into `instr0`. Drives the 4-bit `current_state` that the datapath decodes, and stops on the END opcode or an illegal opcode. The datapath performs register and ALU work only while `current_state == 4'd1`.

## Interface
- `PC_WIDTH`, 16: instruction word address width.
- `START_ADDR`, 0: PC value loaded on reset and on every start.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- `imem_req`  out  1  fetch request; high throughout FETCH.
- `imem_addr`  out  PC_WIDTH  word address, equal to `pc` while `imem_req` is high.
- `imem_ack`  in  1  memory has the data; transfer completes when `imem_req && imem_ack`.
- `imem_rdata`  in  32  instruction word; valid only in the transfer cycle.
- `instr0`  out  32  latched instruction for the datapath.
- `current_state`  out  4  sequencer state code.
- `pc`  out  PC_WIDTH  address of the next word to fetch.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set when HALT is entered because of an unknown opcode.

## Operation
- State codes:
  - IDLE = 4'd0
  - EXEC = 4'd1
  - FETCH = 4'd2
  - DECODE = 4'd3
  - HALT = 4'd15
  - Codes 4–14 are never produced.
- IDLE: `start` loads `pc` with START_ADDR and moves to FETCH.
- FETCH: `imem_req` is held high and `imem_addr` equals `pc`. On the transfer cycle, `instr0` is loaded from `imem_rdata`, `pc` increments by 1, and the state moves to DECODE. Without `imem_ack` the state stays in FETCH indefinitely.
- DECODE: classify `instr0[31:24]`:
  - Executable (02 LIMM16, d2 CP, d3 CPDR, 10, 11, 12, 14, 15, 18, 19) → EXEC.
  - 00 NOP, 01 LB → FETCH; the datapath never sees these in EXEC.
  - ff END → HALT; `illegal` stays 0.
  - Any other opcode → HALT and set `illegal`.
- EXEC: lasts exactly one cycle, then FETCH. `instr0` is stable for the whole cycle.
- HALT: `halted` = 1 and `imem_req` = 0. `start` clears `illegal`, loads START_ADDR and moves to FETCH.
- `start` in FETCH, DECODE or EXEC is ignored.
- PC arithmetic is modulo 2^PC_WIDTH: all-ones + 1 wraps to 0 silently.
- `instr0` changes only on a transfer cycle.

## Timing
- Reset values:
  - `current_state` = IDLE
  - `pc` = START_ADDR
  - `instr0` = 32'h0
  - `imem_req` = 0
  - `imem_addr` = START_ADDR
  - `halted` = 0
  - `illegal` = 0
- Reset asserted mid-fetch drops `imem_req` immediately (async). Any pending ack is discarded.
- `imem_req`, `imem_addr`, `halted` and `current_state` are decoded directly from registers; there is no combinational path from any input.
- Zero-wait memory (ack in the same cycle as req): one instruction takes 3 cycles (FETCH, DECODE, EXEC). NOP/LB take 2 cycles.
- Each wait cycle without ack adds one FETCH cycle.
- `start` is sampled on the rising edge; the first FETCH begins the cycle after the pulse.
- The datapath register write happens on the clock edge that ends EXEC.

## Structure
- Shared package `osecpu_pkg`: state code constants (IDLE, EXEC, FETCH, DECODE, HALT) and opcode constants (NOP, LB, LIMM16, CP, CPDR, ALU group, END). The datapath must use the same package.
- Sub-module `opcode_classify`: pure combinational block, 8-bit opcode → {exec, skip, end, illegal}.
- Top level: one state register, PC register, instruction register, illegal flag.

## Test plan
- Reset, then `start`; memory returns 0x02040005 with zero wait → EXEC occurs 3 cycles after the first FETCH with `instr0` = 0x02040005 and `pc` = 1.
- Program {NOP, LB, 0x14041080, END} → `current_state` sequence 2,3,2,3,2,3,1,2,3,15. EXEC is seen exactly once, and `halted` = 1 with `illegal` = 0.
- Ack delayed 4 cycles → FETCH held 5 cycles, `imem_addr` stable, `instr0` unchanged until the ack cycle.
- Opcode 0x77 → HALT with `illegal` = 1. A following `start` clears `illegal` and refetches from START_ADDR.
- PC_WIDTH = 4 with `pc` = 15 and a NOP fetched → `pc` = 0 and the next `imem_addr` = 0.
- `rst_n` pulsed low while in FETCH awaiting ack → outputs immediately return to reset values, and a late ack is ignored.
